// File: rtl/decoder_4to16.sv
// Registered 4-to-16 one-hot word-line decoder with enable, one cycle of latency.
// Optional build macro DECODER_ONEHOT_CHECK_EN adds a sticky `err` output that flags a non-one-hot output word.
module decoder_4to16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in,
  input  logic        En,
  output logic [15:0] out,
  output logic        valid,
  output logic [3:0]  idx
`ifdef DECODER_ONEHOT_CHECK_EN
  ,
  output logic        err
`endif
);

  logic [15:0] next_out;

  // Next word-line pattern: one line for the selected word, none when disabled.
  always_comb begin
    next_out = 16'h0000;
    if (En) begin
      next_out = 16'h0001 << in;
    end else begin
      next_out = 16'h0000;
    end
  end

  // Output registers; reset clears them without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= 16'h0000;
      valid <= 1'b0;
      idx   <= 4'h0;
    end else begin
      out   <= next_out;
      valid <= En;
      idx   <= in;
    end
  end

`ifdef DECODER_ONEHOT_CHECK_EN
  // True when the word has at most one bit set.
  function automatic logic zero_or_onehot(input logic [15:0] word);
    return ((word & (word - 16'd1)) == 16'h0000);
  endfunction

  // Sticky flag: multi-hot word, or a live word with no line selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (!zero_or_onehot(out) || (valid && (out == 16'h0000))) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_4to16.sv
// Scoreboard bench for decoder_4to16: the driver queues expected words, a monitor pops and checks them every cycle.
module tb_decoder_4to16;

  logic        clk;
  logic        rst;
  logic [3:0]  in;
  logic        En;
  logic [15:0] out;
  logic        valid;
  logic [3:0]  idx;
`ifdef DECODER_ONEHOT_CHECK_EN
  logic        err;
`endif

  typedef struct {
    logic [15:0] word;
    logic        live;
    logic [3:0]  sel;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  decoder_4to16 dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .En    (En),
    .out   (out),
    .valid (valid),
    .idx   (idx)
`ifdef DECODER_ONEHOT_CHECK_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: word index k is the line with value 2**k; disabled means no line.
  function automatic logic [15:0] ref_word(input int sel, input bit en);
    int p;
    p = 1;
    if (!en) return 16'h0000;
    for (int i = 0; i < sel; i++) p = p * 2;
    return p[15:0];
  endfunction

  task automatic drive(input int sel, input bit en);
    exp_t e;
    @(negedge clk);
    in = sel[3:0];
    En = en;
    e.word = ref_word(sel, en);
    e.live = en;
    e.sel  = sel[3:0];
    q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out"},   {16'h0000, out},   32'h0000_0000);
    check({tag, "_valid"}, {31'h0, valid},    32'h0000_0000);
    check({tag, "_idx"},   {28'h0, idx},      32'h0000_0000);
  endtask

  // Monitor: one output word per cycle while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (q.size() > 0)) begin
        e = q.pop_front();
        check("out",   {16'h0000, out},  {16'h0000, e.word});
        check("valid", {31'h0, valid},   {31'h0, e.live});
        check("idx",   {28'h0, idx},     {28'h0, e.sel});
        check("popcount", $countones(out), e.live ? 32'd1 : 32'd0);
`ifdef DECODER_ONEHOT_CHECK_EN
        check("err", {31'h0, err}, 32'h0000_0000);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in  = 4'hA;
    En  = 1'b1;
    #2;
    check_reset_values("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_held");

    // Release with A/1 applied: first decode must be 0x0400.
    @(negedge clk);
    rst = 1'b0;
    drive(4'hA, 1'b1);

    for (int s = 0; s < 5; s++) drive(s, 1'b1);
    drive(5, 1'b0);
    drive(6, 1'b1);

    // Full sweep with a reset pulse between edges partway through.
    for (int s = 0; s < 16; s++) begin
      drive(s, 1'b1);
      if (s == 7) begin
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("reset_mid");
        #1;
        rst = 1'b0;
        #1;
        check_reset_values("reset_mid_release");
      end
    end

    drive(11, 1'b1);
    drive(9, 1'b0);

    for (int n = 0; n < 48; n++) begin
      drive($urandom_range(0, 15), ($urandom % 4) != 0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
